hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Hazard and forwarding controller for the 5-stage MIPS pipeline. It keeps its own shadow of the destination register and remaining result latency (Tnew) for the E, M and W stages. From that shadow it drives the select lines of the D-stage and E-stage forwarding muxes, and it generates the pipeline stall. An optional mult/div busy tracker also stalls HI/LO-class instructions.

## Interface
- MD_MULT_CYC, default 5, busy cycles after a mult/multu start
- MD_DIV_CYC, default 10, busy cycles after a div/divu start
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- d_rs, d_rt  in  5  source register numbers of the D-stage instruction
- d_tuse_rs, d_tuse_rt  in  2  cycles until the operand is needed: 0 = D, 1 = E, 2 = M, 3 = operand not used
- d_dst  in  5  D-stage destination register; 0 means no write
- d_tnew  in  2  cycles after entering E until the result exists: 0 = E (jal/lui), 1 = M (ALU), 2 = W (load)
- d_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- e_md_start, e_md_div  in  1  E-stage starts a mult/div operation this cycle; e_md_div=1 selects divide
- stall  out  1  freeze PC and the F/D register, insert a bubble into E
- d_fwd_rs, d_fwd_rt  out  2  D-mux select: 00 register file, 01 E, 10 M, 11 W
- e_fwd_rs, e_fwd_rt  out  2  E-mux select: 00 pipeline register, 01 M, 10 W
- md_busy  out  1  mult/div unit busy (registered)

## Operation
- Stage slots E, M, W each hold {dst[4:0], tnew[1:0]}. E additionally holds {rs, rt}.
- Every clock:
  - When stall=0: E loads {d_dst, d_tnew, d_rs, d_rt}.
  - When stall=1: E loads a bubble (all fields 0).
  - M loads {E.dst, sat_dec(E.tnew)}.
  - W loads {M.dst, sat_dec(M.tnew)}.
  - sat_dec(0) = 0.
- Stall for the rs operand when all of the following hold:
  - d_tuse_rs != 3 and d_rs != 0
  - (E.dst == d_rs and E.tnew > d_tuse_rs) or (M.dst == d_rs and M.tnew > d_tuse_rs)
- The rt operand is checked in the same way. stall is the OR of the rs and rt checks and the mult/div term.
- D forwarding selection, per operand:
  - Search E, then M, then W, and stop at the youngest stage whose dst matches (dst != 0).
  - If that stage has tnew == 0, select it (01/10/11).
  - Otherwise select 00; an older stage is never used past a younger matching one.
  - Register 0 always gives 00.
- E forwarding selection, per operand:
  - If M.dst == E.rs, E.rs != 0 and M.tnew == 0, select 01.
  - Otherwise, if W.dst == E.rs and E.rs != 0, select 10.
  - Otherwise select 00. The rt operand uses the same rule.
- Mult/div counter (`HAZARD_MD_EN` only):
  - e_md_start loads MD_DIV_CYC when e_md_div=1, otherwise MD_MULT_CYC.
  - If the counter is nonzero and there is no start, it decrements.
  - md_busy = (count != 0).
  - The mult/div stall term is d_md & (md_busy | e_md_start).
  - A start while busy reloads the counter; this is legal but the stall term prevents it in practice.

## Timing
- stall, d_fwd_* and e_fwd_* are combinational from the slot state and the current D inputs. There are no added cycles.
- md_busy is registered and rises the cycle after e_md_start.
- Reset (reset_n low, asynchronous) clears all slots and the counter immediately:
  - stall = 0 and md_busy = 0 regardless of state.
  - With D inputs at 0, every select is 00.
- Reset overrides all other events, including a start or a stall in the same cycle.
- Stage slots update only on the clock edge; nothing updates mid-cycle except reset.

## Configuration
- `HAZARD_MD_EN` defined: the counter, md_busy and the mult/div stall term are compiled in.
- `HAZARD_MD_EN` undefined:
  - No counter; md_busy is tied to 0.
  - d_md, e_md_start and e_md_div are ignored.
  - Parameters remain declared and are unused.

## Test plan
- Load-use: lw $2 (tnew 2), then addu reading $2 (tuse 1) -> stall=1 for exactly 1 cycle; when addu is in E, e_fwd_rs=10.
- Branch after ALU: addu $3 (tnew 1), then beq reading $3 (tuse 0) -> stall=1 for 1 cycle, then d_fwd_rs=10 with no stall.
- jal ($31, tnew 0), then jr $31 (tuse 0) -> stall=0 and d_fwd_rs=01. Same sequence with d_rt unused (tuse 3) -> no rt stall.
- Register $0 dependency: addu $0, then beq $0,$0 -> stall=0 and d_fwd_rs = d_fwd_rt = 00.
- Mult/div (macro on, MD_MULT_CYC=5): mult start, then mflo held in D -> md_busy=1 for 5 cycles and stall=1 for 6 cycles (start cycle plus 5 busy cycles). Macro off -> stall=0 throughout.
- Reset mid-operation: drop reset_n while E holds a load and count=3 -> stall=0 and md_busy=0 in the same cycle, and all selects are 00 after reset.

Source files
------------

// File: rtl/hazard_fwd_ctrl_if.sv
// D/E-stage hazard bundle between pipeline datapath and hazard_fwd_ctrl.
// master = datapath side, slave = controller side.
interface hazard_fwd_ctrl_if;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_dst;
    logic [1:0] d_tnew;
    logic       d_md;
    logic       e_md_start;
    logic       e_md_div;
    logic       stall;
    logic [1:0] d_fwd_rs;
    logic [1:0] d_fwd_rt;
    logic [1:0] e_fwd_rs;
    logic [1:0] e_fwd_rt;
    logic       md_busy;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt,
        output d_dst, d_tnew, d_md,
        output e_md_start, e_md_div,
        input  stall, d_fwd_rs, d_fwd_rt,
        input  e_fwd_rs, e_fwd_rt, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt,
        input  d_dst, d_tnew, d_md,
        input  e_md_start, e_md_div,
        output stall, d_fwd_rs, d_fwd_rt,
        output e_fwd_rs, e_fwd_rt, md_busy
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller with E/M/W dst+Tnew shadow slots.
// Define HAZARD_MD_EN to build in the mult/div busy tracker.
module hazard_fwd_ctrl #(
    parameter int MD_MULT_CYC = 5,
    parameter int MD_DIV_CYC  = 10
) (
    input logic           clk,
    input logic           reset_n,
    hazard_fwd_ctrl_if.slave bus
);

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } slot_t;

    slot_t      e_q;
    slot_t      m_q;
    slot_t      w_q;
    logic [4:0] e_rs_q;
    logic [4:0] e_rt_q;

    logic rs_stall;
    logic rt_stall;
    logic md_stall;

    function automatic logic [1:0] sat_dec(
        input logic [1:0] t
    );
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic op_stall(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input slot_t      e,
        input slot_t      m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (e.dst == r) && (e.tnew > tuse);
        hit_m = (m.dst == r) && (m.tnew > tuse);
        return (tuse != 2'd3) && (r != 5'd0)
            && (hit_e || hit_m);
    endfunction

    // Youngest matching stage wins, even if not ready yet.
    function automatic logic [1:0] d_sel(
        input logic [4:0] r,
        input slot_t      e,
        input slot_t      m,
        input slot_t      w
    );
        logic [1:0] sel;
        sel = 2'b00;
        priority case (1'b1)
            (r == 5'd0):
                sel = 2'b00;
            (e.dst == r):
                sel = (e.tnew == 2'd0) ? 2'b01 : 2'b00;
            (m.dst == r):
                sel = (m.tnew == 2'd0) ? 2'b10 : 2'b00;
            (w.dst == r):
                sel = (w.tnew == 2'd0) ? 2'b11 : 2'b00;
            default:
                sel = 2'b00;
        endcase
        return sel;
    endfunction

    function automatic logic [1:0] e_sel(
        input logic [4:0] r,
        input slot_t      m,
        input slot_t      w
    );
        logic [1:0] sel;
        sel = 2'b00;
        priority case (1'b1)
            (r == 5'd0):
                sel = 2'b00;
            (m.dst == r && m.tnew == 2'd0):
                sel = 2'b01;
            (w.dst == r):
                sel = 2'b10;
            default:
                sel = 2'b00;
        endcase
        return sel;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            e_rs_q <= '0;
            e_rt_q <= '0;
        end else begin
            if (bus.stall) begin
                e_q    <= '0;
                e_rs_q <= '0;
                e_rt_q <= '0;
            end else begin
                e_q.dst  <= bus.d_dst;
                e_q.tnew <= bus.d_tnew;
                e_rs_q   <= bus.d_rs;
                e_rt_q   <= bus.d_rt;
            end
            m_q.dst  <= e_q.dst;
            m_q.tnew <= sat_dec(e_q.tnew);
            w_q.dst  <= m_q.dst;
            w_q.tnew <= sat_dec(m_q.tnew);
        end
    end

`ifdef HAZARD_MD_EN
    localparam int MD_MAX = (MD_DIV_CYC > MD_MULT_CYC)
                          ? MD_DIV_CYC : MD_MULT_CYC;
    localparam int CW = $clog2(MD_MAX + 1);

    logic [CW-1:0] md_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_q <= '0;
        end else if (bus.e_md_start) begin
            md_cnt_q <= bus.e_md_div ? CW'(MD_DIV_CYC)
                                     : CW'(MD_MULT_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_q <= md_cnt_q - CW'(1);
        end
    end

    assign bus.md_busy = (md_cnt_q != '0);
    assign md_stall    = bus.d_md
                       & (bus.md_busy | bus.e_md_start);
`else
    logic md_unused;
    assign md_unused = ^{bus.d_md, bus.e_md_start,
                         bus.e_md_div,
                         MD_MULT_CYC[0], MD_DIV_CYC[0]};
    assign bus.md_busy = 1'b0;
    assign md_stall    = 1'b0;
`endif

    assign rs_stall = op_stall(bus.d_rs, bus.d_tuse_rs,
                               e_q, m_q);
    assign rt_stall = op_stall(bus.d_rt, bus.d_tuse_rt,
                               e_q, m_q);

    // Reset forces stall low even with a same-cycle md start.
    assign bus.stall = reset_n
                     & (rs_stall | rt_stall | md_stall);

    assign bus.d_fwd_rs = d_sel(bus.d_rs, e_q, m_q, w_q);
    assign bus.d_fwd_rt = d_sel(bus.d_rt, e_q, m_q, w_q);
    assign bus.e_fwd_rs = e_sel(e_rs_q, m_q, w_q);
    assign bus.e_fwd_rt = e_sel(e_rt_q, m_q, w_q);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed pipeline
// sequences plus randomized traffic against an age-based model.
module tb_hazard_fwd_ctrl;

    localparam int MULT = 5;
    localparam int DIV  = 10;
`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_fwd_ctrl_if bus ();

    hazard_fwd_ctrl #(
        .MD_MULT_CYC(MULT),
        .MD_DIV_CYC (DIV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    // One record per instruction that entered E; hq[0] is the
    // newest (E), hq[1] one cycle older (M), hq[2] (W).
    typedef struct {
        int dst;
        int tnew;
        int rs;
        int rt;
    } ent_t;

    ent_t hq[3];
    int   cyc;
    int   md_end;
    int   n_chk;
    int   n_pass;

    function automatic int rem(int i);
        return (hq[i].tnew > i) ? hq[i].tnew - i : 0;
    endfunction

    function automatic bit op_stall(int r, int tuse);
        if (tuse == 3 || r == 0) return 1'b0;
        for (int i = 0; i < 2; i++)
            if (hq[i].dst == r && rem(i) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int dsel(int r);
        if (r == 0) return 0;
        for (int i = 0; i < 3; i++)
            if (hq[i].dst == r)
                return (rem(i) == 0) ? i + 1 : 0;
        return 0;
    endfunction

    function automatic int esel(int r);
        if (r == 0) return 0;
        if (hq[1].dst == r && rem(1) == 0) return 1;
        if (hq[2].dst == r) return 2;
        return 0;
    endfunction

    function automatic bit m_busy();
        return MD_EN && (cyc <= md_end);
    endfunction

    function automatic bit m_stall();
        bit s;
        s = op_stall(int'(bus.d_rs), int'(bus.d_tuse_rs))
          | op_stall(int'(bus.d_rt), int'(bus.d_tuse_rt));
        if (MD_EN && bus.d_md && (m_busy() || bus.e_md_start))
            s = 1'b1;
        return s && reset_n;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d cyc %0d",
                      nm, act, exp, cyc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) hq[i] = '{0, 0, 0, 0};
        md_end = -1;
    endtask

    task automatic check_all();
        chk("stall", int'(bus.stall), int'(m_stall()));
        chk("md_busy", int'(bus.md_busy), int'(m_busy()));
        chk("d_fwd_rs", int'(bus.d_fwd_rs), dsel(int'(bus.d_rs)));
        chk("d_fwd_rt", int'(bus.d_fwd_rt), dsel(int'(bus.d_rt)));
        chk("e_fwd_rs", int'(bus.e_fwd_rs), esel(hq[0].rs));
        chk("e_fwd_rt", int'(bus.e_fwd_rt), esel(hq[0].rt));
    endtask

    // Called at negedge: check, then commit the model across posedge.
    task automatic tick();
        bit   s;
        bit   st;
        bit   dv;
        ent_t nx;
        check_all();
        s  = m_stall();
        st = MD_EN && bus.e_md_start;
        dv = bus.e_md_div;
        nx = '{int'(bus.d_dst), int'(bus.d_tnew),
               int'(bus.d_rs), int'(bus.d_rt)};
        @(posedge clk);
        hq[2] = hq[1];
        hq[1] = hq[0];
        hq[0] = s ? '{0, 0, 0, 0} : nx;
        if (st) md_end = cyc + (dv ? DIV : MULT);
        cyc++;
        #1;
    endtask

    task automatic set_d(int rs, int rt, int tur, int tut,
                         int dst, int tnew);
        bus.d_rs      = 5'(rs);
        bus.d_rt      = 5'(rt);
        bus.d_tuse_rs = 2'(tur);
        bus.d_tuse_rt = 2'(tut);
        bus.d_dst     = 5'(dst);
        bus.d_tnew    = 2'(tnew);
    endtask

    int nst;
    int nbz;

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        model_clear();
        set_d(0, 0, 3, 3, 0, 0);
        bus.d_md = 1'b0;
        bus.e_md_start = 1'b0;
        bus.e_md_div = 1'b0;

        @(negedge clk);
        chk("rst_stall", int'(bus.stall), 0);
        chk("rst_busy", int'(bus.md_busy), 0);
        chk("rst_dfwd", int'({bus.d_fwd_rs, bus.d_fwd_rt}), 0);
        chk("rst_efwd", int'({bus.e_fwd_rs, bus.e_fwd_rt}), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use: lw $2 then addu $2.
        set_d(5, 0, 3, 3, 2, 2);
        @(negedge clk); tick();
        set_d(2, 6, 1, 1, 7, 1);
        @(negedge clk);
        chk("lu_stall1", int'(bus.stall), 1);
        tick();
        @(negedge clk);
        chk("lu_stall2", int'(bus.stall), 0);
        tick();
        set_d(0, 0, 3, 3, 0, 0);
        @(negedge clk);
        chk("lu_efwd", int'(bus.e_fwd_rs), 2);
        tick();

        // Branch after ALU.
        set_d(0, 0, 3, 3, 3, 1);
        @(negedge clk); tick();
        set_d(3, 0, 0, 3, 0, 0);
        @(negedge clk);
        chk("br_stall1", int'(bus.stall), 1);
        tick();
        @(negedge clk);
        chk("br_stall2", int'(bus.stall), 0);
        chk("br_dfwd", int'(bus.d_fwd_rs), 2);
        tick();

        // jal then jr $31, rt unused.
        set_d(0, 0, 3, 3, 31, 0);
        @(negedge clk); tick();
        set_d(31, 31, 0, 3, 0, 0);
        @(negedge clk);
        chk("jr_stall", int'(bus.stall), 0);
        chk("jr_dfwd", int'(bus.d_fwd_rs), 1);
        tick();

        // $0 never creates a dependency.
        set_d(0, 0, 3, 3, 0, 1);
        @(negedge clk); tick();
        set_d(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_stall", int'(bus.stall), 0);
        chk("r0_dfwd", int'({bus.d_fwd_rs, bus.d_fwd_rt}), 0);
        tick();

        // mult start with mflo held in D.
        set_d(0, 0, 3, 3, 8, 1);
        bus.d_md = 1'b1;
        bus.e_md_start = 1'b1;
        nst = 0;
        nbz = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nst += int'(bus.stall);
            nbz += int'(bus.md_busy);
            tick();
            bus.e_md_start = 1'b0;
        end
        chk("md_stall_cyc", nst, MD_EN ? 6 : 0);
        chk("md_busy_cyc", nbz, MD_EN ? 5 : 0);
        bus.d_md = 1'b0;

        // Reset while E holds a load and the counter is at 3.
        set_d(0, 0, 3, 3, 0, 0);
        bus.e_md_start = 1'b1;
        @(negedge clk); tick();
        bus.e_md_start = 1'b0;
        @(negedge clk); tick();
        set_d(0, 0, 3, 3, 2, 2);
        @(negedge clk); tick();
        set_d(2, 0, 1, 3, 4, 1);
        bus.d_md = 1'b1;
        @(negedge clk);
        chk("mid_stall", int'(bus.stall), 1);
        chk("mid_busy", int'(bus.md_busy), int'(MD_EN));
        #1;
        reset_n = 1'b0;
        model_clear();
        #1;
        chk("rst_async_stall", int'(bus.stall), 0);
        chk("rst_async_busy", int'(bus.md_busy), 0);
        set_d(0, 0, 3, 3, 0, 0);
        bus.d_md = 1'b0;
        #1;
        chk("rst_sel", int'({bus.d_fwd_rs, bus.d_fwd_rt,
                            bus.e_fwd_rs, bus.e_fwd_rt}), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized traffic with occasional async resets.
        for (int n = 0; n < 3000; n++) begin
            set_d($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
            bus.d_md = ($urandom_range(0, 3) == 0);
            bus.e_md_start = ($urandom_range(0, 7) == 0);
            bus.e_md_div = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                model_clear();
                @(negedge clk);
                chk("rnd_rst_stall", int'(bus.stall), 0);
                chk("rnd_rst_busy", int'(bus.md_busy), 0);
                @(posedge clk);
                #1;
                reset_n = 1'b1;
            end else begin
                @(negedge clk);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
